// File: rtl/vga_sprite_engine.sv
// VGA timing generator with an N-sprite overlay compositor.
// Sprite attributes are shadowed at the frame boundary so that updates never tear.
module vga_sprite_engine #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int CLK_DIV = 2,
  parameter int N_SPR   = 4,
  parameter int SPR_W   = 5,
  parameter int SPR_H   = 5,
  parameter int CW      = 6,
  parameter logic [3*CW-1:0] BG_RGB = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_SPR*10-1:0]    i_spr_x,
  input  logic [N_SPR*10-1:0]    i_spr_y,
  input  logic [N_SPR-1:0]       i_spr_en,
  input  logic [N_SPR*3*CW-1:0]  i_spr_rgb,
  output logic                   o_pix_ce,
  output logic                   o_vga_clk,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_de,
  output logic [9:0]             o_x,
  output logic [9:0]             o_y,
  output logic                   o_frame_start,
  output logic [N_SPR-1:0]       o_hit,
  output logic [CW-1:0]          o_red,
  output logic [CW-1:0]          o_green,
  output logic [CW-1:0]          o_blue
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] VCLK_HI  = DW'(CLK_DIV / 2);
  localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_B  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_E  = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_SYNC_E = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_B  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_E  = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [9:0]  H_OFS    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  V_OFS    = 10'(V_SYNC + V_BP);
  localparam logic [10:0] SW       = 11'(SPR_W);
  localparam logic [10:0] SH       = 11'(SPR_H);

  logic [DW-1:0]   r_div;
  logic            r_tog;
  logic [11:0]     r_h, r_v;
  logic [9:0]      r_sx   [N_SPR];
  logic [9:0]      r_sy   [N_SPR];
  logic [3*CW-1:0] r_srgb [N_SPR];
  logic [N_SPR-1:0] r_sen;
  logic            r_hs, r_vs, r_de, r_fs;
  logic [9:0]      r_x, r_y;
  logic [N_SPR-1:0] r_hit;
  logic [3*CW-1:0] r_rgb;

  logic            w_ce, w_h_last, w_v_last, w_hs_raw, w_vs_raw, w_de_raw;
  logic [9:0]      w_ax, w_ay;
  logic [N_SPR-1:0] w_hit;
  logic [3*CW-1:0] w_rgb;

  assign w_ce      = (r_div == DIV_LAST);
  assign o_pix_ce  = w_ce;
  assign o_vga_clk = (CLK_DIV == 1) ? r_tog : (r_div >= VCLK_HI);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_tog <= 1'b0;
    end else begin
      r_tog <= ~r_tog;
      r_div <= w_ce ? '0 : r_div + 1'b1;
    end
  end

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  // v_cnt steps only on an h wrap, so the final line is full length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_ce) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sen <= '0;
      for (int k = 0; k < N_SPR; k++) begin
        r_sx[k]   <= '0;
        r_sy[k]   <= '0;
        r_srgb[k] <= '0;
      end
    end else if (w_ce && w_h_last && w_v_last) begin
      r_sen <= i_spr_en;
      for (int k = 0; k < N_SPR; k++) begin
        r_sx[k]   <= i_spr_x[10*k +: 10];
        r_sy[k]   <= i_spr_y[10*k +: 10];
        r_srgb[k] <= i_spr_rgb[3*CW*k +: 3*CW];
      end
    end
  end

  assign w_hs_raw = (r_h < H_SYNC_E);
  assign w_vs_raw = (r_v < V_SYNC_E);
  assign w_de_raw = (r_h >= H_ACT_B) && (r_h < H_ACT_E) &&
                    (r_v >= V_ACT_B) && (r_v < V_ACT_E);
  assign w_ax     = r_h[9:0] - H_OFS;
  assign w_ay     = r_v[9:0] - V_OFS;

  // 11-bit compares so x+SPR_W near 1023 cannot wrap into a false hit.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_SPR; k++) begin
      w_hit[k] = r_sen[k] && w_de_raw &&
                 ({1'b0, r_sx[k]} <= {1'b0, w_ax}) && ({1'b0, w_ax} < {1'b0, r_sx[k]} + SW) &&
                 ({1'b0, r_sy[k]} <= {1'b0, w_ay}) && ({1'b0, w_ay} < {1'b0, r_sy[k]} + SH);
    end
  end

  // Walk from the highest index down so the lowest hitting sprite wins.
  always_comb begin
    w_rgb = w_de_raw ? BG_RGB : '0;
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (w_hit[k]) w_rgb = r_srgb[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      r_hit <= '0;
      r_rgb <= '0;
    end else if (w_ce) begin
      r_hs  <= ~w_hs_raw;
      r_vs  <= ~w_vs_raw;
      r_de  <= w_de_raw;
      r_x   <= w_de_raw ? w_ax : '0;
      r_y   <= w_de_raw ? w_ay : '0;
      r_fs  <= w_de_raw && (w_ax == '0) && (w_ay == '0);
      r_hit <= w_hit;
      r_rgb <= w_rgb;
    end
  end

  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_fs;
  assign o_hit         = r_hit;
  assign o_red         = r_rgb[3*CW-1:2*CW];
  assign o_green       = r_rgb[2*CW-1:CW];
  assign o_blue        = r_rgb[CW-1:0];
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine using a shrunken 26x16 raster (16x10 active)
// plus a CLK_DIV=1, N_SPR=1 instance for the undivided pixel rate.
module tb_vga_sprite_engine;
  localparam int CW    = 6;
  localparam int NS    = 4;
  localparam int HT    = 26;
  localparam int VT    = 16;
  localparam int HACT  = 16;
  localparam int VACT  = 10;
  localparam int FRAME = HT * VT;
  localparam logic [17:0] BG    = {6'd1, 6'd2, 6'd3};
  localparam logic [17:0] WHITE = {6'd63, 6'd63, 6'd63};
  localparam logic [17:0] GREEN = {6'd0, 6'd40, 6'd0};
  localparam logic [17:0] RED   = {6'd63, 6'd0, 6'd0};
  localparam logic [17:0] BLUE  = {6'd0, 6'd0, 6'd63};
  localparam logic [17:0] YEL   = {6'd63, 6'd63, 6'd0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NS*10-1:0]   spr_x, spr_y;
  logic [NS-1:0]      spr_en;
  logic [NS*3*CW-1:0] spr_rgb;
  logic pix_ce, vga_clk, hs, vs, de, fs;
  logic [9:0] ox, oy;
  logic [NS-1:0] hit;
  logic [CW-1:0] red, green, blue;
  logic [17:0] rgb;
  assign rgb = {red, green, blue};

  vga_sprite_engine #(
    .H_SYNC(4), .H_BP(3), .H_ACT(16), .H_FP(3),
    .V_SYNC(2), .V_BP(2), .V_ACT(10), .V_FP(2),
    .CLK_DIV(2), .N_SPR(NS), .SPR_W(5), .SPR_H(5), .CW(CW), .BG_RGB(BG)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en), .i_spr_rgb(spr_rgb),
    .o_pix_ce(pix_ce), .o_vga_clk(vga_clk), .o_hs(hs), .o_vs(vs), .o_de(de),
    .o_x(ox), .o_y(oy), .o_frame_start(fs), .o_hit(hit),
    .o_red(red), .o_green(green), .o_blue(blue)
  );

  logic [9:0] z10 = '0;
  logic [0:0] z1 = '0;
  logic [17:0] z18 = '0;
  logic ce1, vclk1, hs1, vs1, de1, fs1;
  logic [9:0] x1, y1;
  logic [0:0] hit1;
  logic [CW-1:0] r1, g1, b1;

  vga_sprite_engine #(
    .H_SYNC(4), .H_BP(3), .H_ACT(16), .H_FP(3),
    .V_SYNC(2), .V_BP(2), .V_ACT(10), .V_FP(2),
    .CLK_DIV(1), .N_SPR(1), .SPR_W(5), .SPR_H(5), .CW(CW), .BG_RGB(BG)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spr_x(z10), .i_spr_y(z10), .i_spr_en(z1), .i_spr_rgb(z18),
    .o_pix_ce(ce1), .o_vga_clk(vclk1), .o_hs(hs1), .o_vs(vs1), .o_de(de1),
    .o_x(x1), .o_y(y1), .o_frame_start(fs1), .o_hit(hit1),
    .o_red(r1), .o_green(g1), .o_blue(b1)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int n_hs, n_vs, n_de, n_fs, n_blank_bad, first_hs;
  int fs_x, fs_y;
  logic [17:0] fs_rgb;
  logic [17:0] img  [0:VACT-1][0:HACT-1];
  logic [NS-1:0] himg [0:VACT-1][0:HACT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_spr(input int k, input int x, input int y, input logic en, input logic [17:0] c);
    spr_x[10*k +: 10]    = 10'(x);
    spr_y[10*k +: 10]    = 10'(y);
    spr_en[k]            = en;
    spr_rgb[18*k +: 18]  = c;
  endtask

  task automatic cfg_overlap();
    set_spr(0, 8, 2, 1'b1, RED);
    set_spr(1, 14, 8, 1'b0, GREEN);
    set_spr(2, 8, 2, 1'b1, BLUE);
    set_spr(3, 0, 0, 1'b0, YEL);
  endtask

  // Advance to just after the next pixel-enable edge.
  task automatic next_ce();
    int n;
    n = 0;
    @(negedge clk);
    while (!pix_ce && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ce) begin
      errors++;
      $display("FAIL ce_timeout: observed=no o_pix_ce expected=o_pix_ce within 8 clocks");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "pixel enable never asserted");
    end
    @(posedge clk);
    #1;
  endtask

  // Capture one full frame of outputs; optionally apply the overlap config mid-frame.
  task automatic scan_frame(input int chg_y);
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_blank_bad = 0; first_hs = -1;
    fs_x = -1; fs_y = -1; fs_rgb = '0;
    for (int y = 0; y < VACT; y++)
      for (int x = 0; x < HACT; x++) begin
        img[y][x]  = 'x;
        himg[y][x] = 'x;
      end
    for (int i = 0; i < FRAME; i++) begin
      next_ce();
      if (i == 0) first_hs = int'(hs);
      if (!hs) n_hs++;
      if (!vs) n_vs++;
      if (de) begin
        n_de++;
        img[oy][ox]  = rgb;
        himg[oy][ox] = hit;
      end else if (rgb != '0 || ox != '0 || oy != '0 || hit != '0) begin
        n_blank_bad++;
      end
      if (fs) begin
        n_fs++;
        fs_x = int'(ox);
        fs_y = int'(oy);
        fs_rgb = rgb;
      end
      if (chg_y >= 0 && de && int'(oy) == chg_y && ox == '0) cfg_overlap();
    end
  endtask

  function automatic int cnt_rgb(input logic [17:0] c);
    int n = 0;
    for (int y = 0; y < VACT; y++)
      for (int x = 0; x < HACT; x++)
        if (img[y][x] === c) n++;
    return n;
  endfunction

  function automatic int cnt_hit(input logic [NS-1:0] h);
    int n = 0;
    for (int y = 0; y < VACT; y++)
      for (int x = 0; x < HACT; x++)
        if (himg[y][x] === h) n++;
    return n;
  endfunction

  function automatic int cnt_hit_bit(input int b);
    int n = 0;
    for (int y = 0; y < VACT; y++)
      for (int x = 0; x < HACT; x++)
        if (himg[y][x][b] !== 1'b0) n++;
    return n;
  endfunction

  initial begin
    int n, ce_zero, same, p0, p1;
    logic prev;
    rst_n = 1'b0;
    spr_x = '0; spr_y = '0; spr_en = '0; spr_rgb = '0;
    set_spr(0, 0, 0, 1'b1, WHITE);
    set_spr(1, 14, 8, 1'b1, GREEN);
    set_spr(2, 16, 0, 1'b1, YEL);
    set_spr(3, 3, 3, 1'b0, BLUE);
    repeat (3) @(negedge clk);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_de", de, 0);
    check("rst_xy", {ox, oy}, 0);
    check("rst_fs", fs, 0);
    check("rst_hit", hit, 0);
    check("rst_rgb", rgb, 0);
    check("rst_ce", pix_ce, 0);
    rst_n = 1'b1;

    // Frame A: timing, shadow still holds the reset (disabled) sprites
    scan_frame(-1);
    check("a_first_hs", first_hs, 0);
    check("a_hs_low", n_hs, 4 * VT);
    check("a_vs_low", n_vs, 2 * HT);
    check("a_de", n_de, HACT * VACT);
    check("a_fs_count", n_fs, 1);
    check("a_fs_pos", fs_x * 100 + fs_y, 0);
    check("a_blank", n_blank_bad, 0);
    check("a_all_bg", cnt_rgb(BG), HACT * VACT);

    // Frame B: sprites latched; new config written mid-frame at o_y==2
    scan_frame(2);
    check("b_white_cnt", cnt_rgb(WHITE), 25);
    check("b_green_cnt", cnt_rgb(GREEN), 4);
    check("b_px_0_0", img[0][0], WHITE);
    check("b_px_4_4", img[4][4], WHITE);
    check("b_px_5_0", img[0][5], BG);
    check("b_px_0_5", img[5][0], BG);
    check("b_px_14_8", img[8][14], GREEN);
    check("b_px_15_9", img[9][15], GREEN);
    check("b_px_13_8", img[8][13], BG);
    check("b_px_15_7", img[7][15], BG);
    check("b_hit_0_0", himg[0][0], 4'b0001);
    check("b_hit_15_9", himg[9][15], 4'b0010);
    check("b_x640_nohit", cnt_hit_bit(2), 0);
    check("b_yel_cnt", cnt_rgb(YEL), 0);
    check("b_fs_white", fs_rgb, WHITE);
    check("b_old_cfg_8_4", img[4][8], BG);
    check("b_blank", n_blank_bad, 0);

    // Frame C: sprites 0 (red) and 2 (blue) stacked at (8,2)
    scan_frame(-1);
    check("c_red_cnt", cnt_rgb(RED), 25);
    check("c_blue_cnt", cnt_rgb(BLUE), 0);
    check("c_hit_0101", cnt_hit(4'b0101), 25);
    check("c_px_8_2", img[2][8], RED);
    check("c_px_12_6", img[6][12], RED);
    check("c_px_13_2", img[2][13], BG);
    check("c_px_8_7", img[7][8], BG);
    check("c_px_0_0", img[0][0], BG);
    check("c_white_cnt", cnt_rgb(WHITE), 0);
    check("c_fs_count", n_fs, 1);

    // pixel enable period and DAC clock phase
    check("ce_low_phase", pix_ce, 0);
    check("vclk_low_phase", vga_clk, 0);
    @(posedge clk); #1;
    check("ce_high_phase", pix_ce, 1);
    check("vclk_high_phase", vga_clk, 1);

    // asynchronous reset in the middle of an active line
    n = 0;
    while (!(de && ox == 10'd5) && n < FRAME) begin
      next_ce();
      n++;
    end
    check("mid_reset_point", {de, ox}, {1'b1, 10'd5});
    #2 rst_n = 1'b0;
    #1;
    check("mr_de", de, 0);
    check("mr_x", ox, 0);
    check("mr_y", oy, 0);
    check("mr_rgb", rgb, 0);
    check("mr_hit", hit, 0);
    check("mr_hs_vs", {hs, vs}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    scan_frame(-1);
    check("r_first_hs", first_hs, 0);
    check("r_hs_low", n_hs, 4 * VT);
    check("r_de", n_de, HACT * VACT);
    check("r_sprites_off", cnt_rgb(BG), HACT * VACT);

    // undivided build: constant enable, toggling DAC clock, HT-clock line
    ce_zero = 0;
    same = 0;
    @(negedge clk);
    prev = vclk1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ce1 !== 1'b1) ce_zero++;
      if (vclk1 === prev) same++;
      prev = vclk1;
    end
    check("d1_ce_const", ce_zero, 0);
    check("d1_vclk_toggle", same, 0);
    p0 = -1;
    p1 = -1;
    prev = hs1;
    for (int i = 0; i < 4 * HT && p1 < 0; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && hs1 === 1'b0) begin
        if (p0 < 0) p0 = i;
        else p1 = i;
      end
      prev = hs1;
    end
    check("d1_line_period", p1 - p0, HT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised VGA timing generator with an N-sprite overlay compositor. It supersedes the fixed 640x480 single-box generator.
- Produces sync, data-enable, active-area pixel coordinates and composited RGB. Everything runs from one system clock, gated by an internal pixel clock-enable.
- Sits between the game-state logic, which supplies sprite positions and colours, and the DAC/VGA pins.
- Sprite inputs are double-buffered so that updates are tear-free: they take effect only at frame boundaries.

Parameters:
- H_SYNC, 96, horizontal sync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACT, 640, horizontal active pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, vertical active lines
- V_FP, 10, vertical front porch
- CLK_DIV, 2, i_clk cycles per pixel (>=1)
- N_SPR, 4, number of sprites (1..8)
- SPR_W, 5, sprite width in pixels
- SPR_H, 5, sprite height in lines
- CW, 6, bits per colour channel
- BG_RGB, 0, background colour {r,g,b}, width 3*CW

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  async active-low reset
- i_spr_x  in  N_SPR*10  per-sprite active-area X of left edge; sprite k at [10k+9:10k]
- i_spr_y  in  N_SPR*10  per-sprite active-area Y of top edge; Y grows downward
- i_spr_en  in  N_SPR  per-sprite enable
- i_spr_rgb  in  N_SPR*3*CW  per-sprite colour {r,g,b}
- o_pix_ce  out  1  pixel clock-enable, one i_clk wide
- o_vga_clk  out  1  pixel clock for DAC; high during the second half of each pixel period (CLK_DIV>=2), else i_clk-rate toggle
- o_hs  out  1  horizontal sync, active low
- o_vs  out  1  vertical sync, active low
- o_de  out  1  active-video flag
- o_x  out  10  active X of current output pixel (0 when !o_de)
- o_y  out  10  active Y of current output pixel (0 when !o_de)
- o_frame_start  out  1  one-ce pulse at the first active pixel of each frame
- o_hit  out  N_SPR  per-sprite coverage of current pixel (collision detection)
- o_red/o_green/o_blue  out  CW each  pixel colour

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. During reset:
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - o_hs=1, o_vs=1, o_de=0, o_x=0, o_y=0, o_frame_start=0, o_hit=0, RGB=0.
  - Shadow sprite registers: all disabled, position 0, colour 0.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - o_pix_ce=1 when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives o_pix_ce constantly 1 after reset.
- Counters advance only when ce=1:
  - H_TOT=H_SYNC+H_BP+H_ACT+H_FP; V_TOT likewise.
  - h_cnt wraps H_TOT-1 -> 0.
  - v_cnt increments only on an h wrap, and wraps V_TOT-1 -> 0 only on an h wrap, so the last line is full length.
- Sync: hs_raw = h_cnt < H_SYNC; vs_raw = v_cnt < V_SYNC.
- Active region: de_raw = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT, AND the same form for V. The upper bound is exclusive: exactly H_ACT x V_ACT pixels.
- Coordinates: ax = h_cnt-(H_SYNC+H_BP), ay = v_cnt-(V_SYNC+V_BP), both valid only when de_raw.
- Shadow latch: on the ce where h_cnt==H_TOT-1 and v_cnt==V_TOT-1, all i_spr_* inputs are copied into the shadow registers. Input changes at any other time have no effect until the next boundary.
- Hit test per sprite k, using 11-bit unsigned arithmetic with no wrap:
  - hit_k = en_k && de_raw && x_k <= ax < x_k+SPR_W && y_k <= ay < y_k+SPR_H.
  - Sprites extending past the right or bottom edge are clipped naturally.
  - A sprite with x >= H_ACT or y >= V_ACT never hits.
- Priority: lowest index with hit wins; its colour drives RGB. No hit and de_raw selects BG_RGB. !de_raw forces RGB=0.
- Pipeline: a single output register stage, updated on ce.
  - o_hs, o_vs, o_de, o_x, o_y, o_hit, RGB and o_frame_start reflect the counter state of the previous ce, all mutually aligned.
  - Latency is 1 pixel period.
- o_frame_start = 1 for the pixel with ax==0 and ay==0, one ce wide.
- Reset asserted mid-frame: all outputs return to reset values immediately; restart is from h=v=0 with sprites disabled.
- Outputs hold their values between ce pulses.

Test Plan:
- Reset then run with defaults:
  - o_hs low for exactly 96 ce per 800-ce line.
  - o_vs low for exactly 2 lines (1600 ce) per 525-line frame.
  - o_de high for exactly 640x480 = 307200 ce per frame.
  - o_pix_ce period is 2 i_clk.
- Sprite 0 at (0,0), en=1, colour all-ones:
  - RGB = 63/63/63 for o_x 0..4 and o_y 0..4; BG elsewhere.
  - o_frame_start coincides with the first white pixel.
- Sprites 0 and 2 both at (100,50), colours red and blue:
  - Overlap pixels are red.
  - o_hit = 4'b0101 for all 25 pixels of the overlap.
- Sprite 1 at (638,478):
  - Only a 2x2 region is drawn at o_x 638..639, o_y 478..479.
  - No colour appears outside the active area.
  - Sprite at x=640 never hits.
- Change i_spr_x of sprite 0 from 10 to 200 at o_y=100 mid-frame:
  - The current frame still draws at x=10.
  - The next frame draws at x=200.
- Assert i_rst_n low mid-line at h_cnt=300:
  - Outputs go to reset values asynchronously.
  - After release, the first o_hs low pulse starts on the second ce.
- CLK_DIV=1, N_SPR=1 build: o_pix_ce constant 1 and line period 800 i_clk.
